// File: rtl/axi_read_mux.sv
// Read-channel mux behind a 4-master round-robin arbiter: accepts the granted AR,
// forwards it to the slave through a register stage, and routes R beats back to the locked master.
module axi_read_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [3:0]          rgrnt,
  input  logic [3:0]          m_ARVALID,
  output logic [3:0]          m_ARREADY,
  input  logic [4*ADDR_W-1:0] m_ARADDR,
  input  logic [4*8-1:0]      m_ARLEN,
  input  logic [4*2-1:0]      m_ARBURST,
  output logic [3:0]          m_RVALID,
  input  logic [3:0]          m_RREADY,
  output logic [DATA_W-1:0]   m_RDATA,
  output logic [1:0]          m_RRESP,
  output logic                m_RLAST,
  output logic                s_ARVALID,
  input  logic                s_ARREADY,
  output logic [ADDR_W-1:0]   s_ARADDR,
  output logic [7:0]          s_ARLEN,
  output logic [1:0]          s_ARBURST,
  input  logic                s_RVALID,
  output logic                s_RREADY,
  input  logic [DATA_W-1:0]   s_RDATA,
  input  logic [1:0]          s_RRESP,
  input  logic                s_RLAST,
  output logic                busy,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                s_arvalid_q, s_arvalid_d;
  logic [ADDR_W-1:0]   s_araddr_q, s_araddr_d;
  logic [7:0]          s_arlen_q, s_arlen_d;
  logic [1:0]          s_arburst_q, s_arburst_d;
  logic                len_err_q, len_err_d;

  logic                grant_onehot;
  logic [1:0]          grant_idx;
  logic                beat;

  assign grant_onehot = (rgrnt != 4'b0000) && ((rgrnt & (rgrnt - 4'd1)) == 4'b0000);

  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rgrnt[i]) grant_idx = i[1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    beat_cnt_d  = beat_cnt_q;
    s_arvalid_d = s_arvalid_q;
    s_araddr_d  = s_araddr_q;
    s_arlen_d   = s_arlen_q;
    s_arburst_d = s_arburst_q;
    len_err_d   = 1'b0;
    m_ARREADY   = 4'b0000;
    m_RVALID    = 4'b0000;
    s_RREADY    = 1'b0;
    beat        = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so the ready stays low while the arbiter grant is already live.
        if (grant_onehot && ARESETn) m_ARREADY = rgrnt;
        if ((m_ARVALID & m_ARREADY) != 4'b0000) begin
          sel_d       = grant_idx;
          s_araddr_d  = m_ARADDR[grant_idx*ADDR_W +: ADDR_W];
          s_arlen_d   = m_ARLEN[grant_idx*8 +: 8];
          s_arburst_d = m_ARBURST[grant_idx*2 +: 2];
          beat_cnt_d  = m_ARLEN[grant_idx*8 +: 8];
          s_arvalid_d = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (s_ARREADY) begin
          s_arvalid_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        m_RVALID[sel_q] = s_RVALID;
        s_RREADY        = m_RREADY[sel_q];
        beat            = s_RVALID & s_RREADY;
        if (beat) begin
          len_err_d = (s_RLAST && beat_cnt_q != 8'd0) || (!s_RLAST && beat_cnt_q == 8'd0);
          if (s_RLAST) state_d = IDLE;
          else if (beat_cnt_q != 8'd0) beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      beat_cnt_q  <= 8'd0;
      s_arvalid_q <= 1'b0;
      s_araddr_q  <= '0;
      s_arlen_q   <= 8'd0;
      s_arburst_q <= 2'd0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      beat_cnt_q  <= beat_cnt_d;
      s_arvalid_q <= s_arvalid_d;
      s_araddr_q  <= s_araddr_d;
      s_arlen_q   <= s_arlen_d;
      s_arburst_q <= s_arburst_d;
      len_err_q   <= len_err_d;
    end
  end

  assign s_ARVALID = s_arvalid_q;
  assign s_ARADDR  = s_araddr_q;
  assign s_ARLEN   = s_arlen_q;
  assign s_ARBURST = s_arburst_q;
  assign m_RDATA   = s_RDATA;
  assign m_RRESP   = s_RRESP;
  assign m_RLAST   = s_RLAST;
  assign busy      = (state_q != IDLE);
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_axi_read_mux.sv
// Directed bench for axi_read_mux: reset, single beat, stalled burst with grant toggling,
// bad grants, length error and asynchronous reset mid-burst.
module tb_axi_read_mux;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                ACLK = 1'b0;
  logic                ARESETn;
  logic [3:0]          rgrnt;
  logic [3:0]          m_ARVALID;
  logic [3:0]          m_ARREADY;
  logic [4*ADDR_W-1:0] m_ARADDR;
  logic [4*8-1:0]      m_ARLEN;
  logic [4*2-1:0]      m_ARBURST;
  logic [3:0]          m_RVALID;
  logic [3:0]          m_RREADY;
  logic [DATA_W-1:0]   m_RDATA;
  logic [1:0]          m_RRESP;
  logic                m_RLAST;
  logic                s_ARVALID;
  logic                s_ARREADY;
  logic [ADDR_W-1:0]   s_ARADDR;
  logic [7:0]          s_ARLEN;
  logic [1:0]          s_ARBURST;
  logic                s_RVALID;
  logic                s_RREADY;
  logic [DATA_W-1:0]   s_RDATA;
  logic [1:0]          s_RRESP;
  logic                s_RLAST;
  logic                busy;
  logic                len_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi_read_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .rgrnt(rgrnt),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
    .m_ARLEN(m_ARLEN), .m_ARBURST(m_ARBURST),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA),
    .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR),
    .s_ARLEN(s_ARLEN), .s_ARBURST(s_ARBURST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA),
    .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .busy(busy), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Load master m's AR payload into the packed buses.
  task automatic set_ar(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    m_ARADDR[m*ADDR_W +: ADDR_W] = addr;
    m_ARLEN[m*8 +: 8]            = len;
    m_ARBURST[m*2 +: 2]          = burst;
  endtask

  // Handshake master m through IDLE and ADDR, leaving the DUT in DATA.
  task automatic open_burst(input int m, input logic [31:0] addr, input logic [7:0] len, input string tag);
    logic [3:0] g;
    g = 4'b0001 << m;
    set_ar(m, addr, len, 2'b01);
    rgrnt = g; m_ARVALID = g;
    #1 chk({tag, "_arready"}, m_ARREADY, g);
    tick();
    m_ARVALID = 4'b0000;
    chk({tag, "_s_arvalid"}, s_ARVALID, 1'b1);
    chk({tag, "_s_araddr"}, s_ARADDR, addr);
    chk({tag, "_s_arlen"}, s_ARLEN, len);
    s_ARREADY = 1'b1;
    tick();
    s_ARREADY = 1'b0;
    chk({tag, "_s_arvalid_clr"}, s_ARVALID, 1'b0);
  endtask

  initial begin
    ARESETn = 1'b0; rgrnt = 4'b0001; m_ARVALID = 4'hF;
    m_ARADDR = '0; m_ARLEN = '0; m_ARBURST = '0; m_RREADY = 4'b0000;
    s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RDATA = '0; s_RRESP = 2'b00; s_RLAST = 1'b0;

    // 1: reset with a live grant and all ARVALIDs high
    #22;
    chk("rst_arready", m_ARREADY, 4'b0000);
    chk("rst_rvalid", m_RVALID, 4'b0000);
    chk("rst_s_rready", s_RREADY, 1'b0);
    chk("rst_s_arvalid", s_ARVALID, 1'b0);
    chk("rst_s_araddr", s_ARADDR, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    m_ARVALID = 4'b0000;
    tick();
    ARESETn = 1'b1;
    tick();

    // 2: single beat from master 0
    set_ar(0, 32'h0000_1000, 8'd0, 2'b01);
    rgrnt = 4'b0001; m_ARVALID = 4'b0001;
    #1 chk("t2_arready", m_ARREADY, 4'b0001);
    chk("t2_s_arvalid_pre", s_ARVALID, 1'b0);
    tick();
    m_ARVALID = 4'b0000;
    chk("t2_s_arvalid", s_ARVALID, 1'b1);
    chk("t2_s_araddr", s_ARADDR, 32'h0000_1000);
    chk("t2_s_arburst", s_ARBURST, 2'b01);
    chk("t2_busy", busy, 1'b1);
    s_ARREADY = 1'b1;
    tick();
    s_ARREADY = 1'b0;
    s_RVALID = 1'b1; s_RLAST = 1'b1; s_RDATA = 32'hDEAD_BEEF; s_RRESP = 2'b10; m_RREADY = 4'hF;
    #1 chk("t2_rvalid", m_RVALID, 4'b0001);
    chk("t2_s_rready", s_RREADY, 1'b1);
    chk("t2_rdata", m_RDATA, 32'hDEAD_BEEF);
    chk("t2_rresp", m_RRESP, 2'b10);
    chk("t2_rlast", m_RLAST, 1'b1);
    tick();
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    chk("t2_busy_fall", busy, 1'b0);
    chk("t2_len_err", len_err, 1'b0);

    // 3: 4-beat burst on master 2 with grant moved to master 0 and two stall cycles
    set_ar(2, 32'h0000_2000, 8'd3, 2'b01);
    rgrnt = 4'b0100; m_ARVALID = 4'b0101;
    #1 chk("t3_arready", m_ARREADY, 4'b0100);
    tick();
    rgrnt = 4'b0001; m_ARVALID = 4'b0001;
    #1 chk("t3_m0_blocked_addr", m_ARREADY, 4'b0000);
    chk("t3_s_arlen", s_ARLEN, 8'd3);
    chk("t3_s_araddr", s_ARADDR, 32'h0000_2000);
    s_ARREADY = 1'b1;
    tick();
    s_ARREADY = 1'b0;
    s_RVALID = 1'b1; s_RDATA = 32'h0000_0001; m_RREADY = 4'b1011;
    for (int s = 0; s < 2; s++) begin
      #1 chk("t3_stall_rvalid", m_RVALID, 4'b0100);
      chk("t3_stall_s_rready", s_RREADY, 1'b0);
      tick();
    end
    m_RREADY = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      s_RDATA = 32'h0000_0001 + b;
      s_RLAST = (b == 3);
      #1 chk("t3_beat_rvalid", m_RVALID, 4'b0100);
      chk("t3_beat_s_rready", s_RREADY, 1'b1);
      chk("t3_m0_blocked_data", m_ARREADY, 4'b0000);
      tick();
      chk("t3_len_err", len_err, 1'b0);
    end
    s_RVALID = 1'b0; s_RLAST = 1'b0; m_ARVALID = 4'b0000;
    chk("t3_busy_fall", busy, 1'b0);

    // 4: multi-hot and zero grant
    rgrnt = 4'b0110; m_ARVALID = 4'hF;
    #1 chk("t4_multihot_arready", m_ARREADY, 4'b0000);
    tick();
    chk("t4_multihot_busy", busy, 1'b0);
    rgrnt = 4'b0000;
    #1 chk("t4_zero_arready", m_ARREADY, 4'b0000);
    tick();
    chk("t4_zero_busy", busy, 1'b0);
    chk("t4_zero_s_arvalid", s_ARVALID, 1'b0);
    m_ARVALID = 4'b0000;

    // 5: LEN=1 but RLAST on the first beat
    open_burst(1, 32'h0000_3000, 8'd1, "t5");
    s_RVALID = 1'b1; s_RLAST = 1'b1; m_RREADY = 4'b0010;
    #1 chk("t5_rvalid", m_RVALID, 4'b0010);
    tick();
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    chk("t5_len_err_pulse", len_err, 1'b1);
    chk("t5_busy", busy, 1'b0);
    tick();
    chk("t5_len_err_clear", len_err, 1'b0);

    // 6: asynchronous reset during beat 2 of 4 on master 3
    open_burst(3, 32'h0000_4000, 8'd3, "t6");
    s_RVALID = 1'b1; m_RREADY = 4'b1000;
    tick();
    #1 chk("t6_beat2_rvalid", m_RVALID, 4'b1000);
    ARESETn = 1'b0;
    #1 chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rvalid", m_RVALID, 4'b0000);
    chk("t6_rst_s_rready", s_RREADY, 1'b0);
    s_RVALID = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();
    open_burst(0, 32'h0000_5000, 8'd0, "t6_after");
    s_RVALID = 1'b1; s_RLAST = 1'b1; m_RREADY = 4'b0001;
    #1 chk("t6_after_rvalid", m_RVALID, 4'b0001);
    tick();
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    chk("t6_after_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
